range_serializer: RTL and testbench

Downstream consumer of a range-derived vector: accepts a parallel word whose width comes from a constant function of a parameter (WIDTH = clog2(DEPTH); DEPTH=5 gives range 2 downto 0, left=2, right=0). It emits the word one bit per accepted cycle, walking the index from the left bound to the right bound. Valid/ready handshakes sit on both sides. The block exercises function-elaborated ranges in live sequential logic rather than in static signal declarations.

---
 rtl/range_serializer_pkg.sv | 26 ++
 rtl/range_serializer_index_counter.sv | 34 +++
 rtl/range_serializer.sv | 113 +++++++++++
 tb/tb_range_serializer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/range_serializer_pkg.sv
// Shared types and range helpers for the range serializer: the width function,
// FSM state encoding and the elaborated bit-range bounds.
package range_serializer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int unsigned RANGE_RIGHT = 0;

    // Smallest w with 2**w >= n, never below 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'(1) << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int unsigned range_left(input int unsigned depth);
        return clog2(depth) - 1;
    endfunction

endpackage

// File: rtl/range_serializer_index_counter.sv
// Bit-index down-counter: loads the left bound, steps toward the right bound,
// and flags when it sits on the right bound.
module range_index_counter
    import range_serializer_pkg::*;
#(
    parameter int unsigned IDXW  = 4,
    parameter int unsigned LEFT  = 2,
    parameter int unsigned RIGHT = RANGE_RIGHT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_en,
    output logic [IDXW-1:0] o_index,
    output logic            o_at_right
);

    logic [IDXW-1:0] r_idx;

    // Load has priority so a back-to-back word restarts at the left bound.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (i_load) begin
            r_idx <= IDXW'(LEFT);
        end else if (i_en) begin
            r_idx <= r_idx - IDXW'(1);
        end
    end

    assign o_index    = r_idx;
    assign o_at_right = (r_idx == IDXW'(RIGHT));

endmodule

// File: rtl/range_serializer.sv
// Parallel-to-serial converter: emits a clog2(DEPTH)-bit word one bit per
// accepted cycle, MSB (left bound) first, with valid/ready on both sides.
module range_serializer
    import range_serializer_pkg::*;
#(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned IDXW  = 4,
    parameter int unsigned CNTW  = 8,
    localparam int unsigned WIDTH = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [IDXW-1:0]  out_index,
    output logic             out_last,
    output logic [CNTW-1:0]  words_done
);

    localparam int unsigned LEFT  = range_left(DEPTH);
    localparam int unsigned RIGHT = RANGE_RIGHT;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [CNTW-1:0]  r_words;
    logic [IDXW-1:0]  w_index;
    logic [WIDTH-1:0] w_sel;
    logic             w_at_right;
    logic             w_last_xfer;
    logic             w_in_ready;
    logic             w_load;
    logic             w_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; a last-bit transfer can reload in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_last_xfer = 1'b0;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_last_xfer = out_ready && w_at_right;
                w_dec       = out_ready && !w_at_right;
                w_in_ready  = w_last_xfer;
                if (w_last_xfer) begin
                    if (in_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_words <= '0;
        end else begin
            if (w_load) begin
                r_shreg <= in_data;
            end
            if (w_last_xfer) begin
                r_words <= r_words + CNTW'(1);
            end
        end
    end

    range_index_counter #(
        .IDXW  (IDXW),
        .LEFT  (LEFT),
        .RIGHT (RIGHT)
    ) u_index (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_en       (w_dec),
        .o_index    (w_index),
        .o_at_right (w_at_right)
    );

    assign w_sel      = r_shreg >> w_index;
    assign out_bit    = w_sel[0];
    assign out_valid  = (r_state == ST_SHIFT);
    assign out_last   = (r_state == ST_SHIFT) && w_at_right;
    assign out_index  = w_index;
    assign in_ready   = w_in_ready;
    assign words_done = r_words;

endmodule

// File: tb/tb_range_serializer.sv
// Scoreboard bench for range_serializer at DEPTH=5, 9 and 1: stimulus pushes the
// expected bit stream, per-instance monitors pop and compare on each transfer.
module tb_range_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, out_ready;

    logic       iv5, ir5, ov5, ob5, ol5;
    logic [2:0] id5;
    logic [3:0] oi5;
    logic [7:0] wd5;

    logic       iv9, ir9, ov9, ob9, ol9;
    logic [3:0] id9;
    logic [3:0] oi9;
    logic [7:0] wd9;

    logic       iv1, ir1, ov1, ob1, ol1;
    logic [0:0] id1;
    logic [3:0] oi1;
    logic [7:0] wd1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic b;
        int   idx;
        logic last;
    } exp_t;

    exp_t q5[$], q9[$], q1[$];
    exp_t m5, m9, m1;

    range_serializer #(.DEPTH(5), .IDXW(4), .CNTW(8)) u5 (
        .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .in_data(id5),
        .out_valid(ov5), .out_ready(out_ready), .out_bit(ob5), .out_index(oi5),
        .out_last(ol5), .words_done(wd5)
    );

    range_serializer #(.DEPTH(9), .IDXW(4), .CNTW(8)) u9 (
        .clk(clk), .rst(rst), .in_valid(iv9), .in_ready(ir9), .in_data(id9),
        .out_valid(ov9), .out_ready(out_ready), .out_bit(ob9), .out_index(oi9),
        .out_last(ol9), .words_done(wd9)
    );

    range_serializer #(.DEPTH(1), .IDXW(4), .CNTW(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(out_ready), .out_bit(ob1), .out_index(oi1),
        .out_last(ol1), .words_done(wd1)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 5) ? ir5 : (sel == 9) ? ir9 : ir1;
    endfunction

    // Queue the expected bits of one word, then hold in_valid until accepted.
    task automatic send(input int sel, input logic [3:0] d, output int waits);
        exp_t e;
        int   n;
        n = (sel == 5) ? 3 : (sel == 9) ? 4 : 1;
        for (int i = n - 1; i >= 0; i--) begin
            e.b    = d[i];
            e.idx  = i;
            e.last = (i == 0);
            case (sel)
                5:       q5.push_back(e);
                9:       q9.push_back(e);
                default: q1.push_back(e);
            endcase
        end
        case (sel)
            5:       begin iv5 = 1'b1; id5 = d[2:0]; end
            9:       begin iv9 = 1'b1; id9 = d;      end
            default: begin iv1 = 1'b1; id1 = d[0];   end
        endcase
        waits = 0;
        while (!rdy(sel) && waits < 20) begin
            step();
            waits++;
        end
        chk($sformatf("accept_u%0d", sel), int'(rdy(sel)), 1);
        step();
        iv5 = 1'b0;
        iv9 = 1'b0;
        iv1 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && ov5 && out_ready) begin
            if (q5.size() == 0) begin
                total++; bad++;
                $display("FAIL u5_unexpected_bit actual_index=%0d required=none", oi5);
            end else begin
                m5 = q5.pop_front();
                chk("u5_bit", int'(ob5), int'(m5.b));
                chk("u5_index", int'(oi5), m5.idx);
                chk("u5_last", int'(ol5), int'(m5.last));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov9 && out_ready) begin
            if (q9.size() == 0) begin
                total++; bad++;
                $display("FAIL u9_unexpected_bit actual_index=%0d required=none", oi9);
            end else begin
                m9 = q9.pop_front();
                chk("u9_bit", int'(ob9), int'(m9.b));
                chk("u9_index", int'(oi9), m9.idx);
                chk("u9_last", int'(ol9), int'(m9.last));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov1 && out_ready) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL u1_unexpected_bit actual_index=%0d required=none", oi1);
            end else begin
                m1 = q1.pop_front();
                chk("u1_bit", int'(ob1), int'(m1.b));
                chk("u1_index", int'(oi1), m1.idx);
                chk("u1_last", int'(ol1), int'(m1.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        rst = 1'b1; out_ready = 1'b1;
        iv5 = 1'b0; iv9 = 1'b0; iv1 = 1'b0;
        id5 = '0;   id9 = '0;   id1 = '0;
        step();
        step();
        rst = 1'b0;

        // Reset values
        chk("rst_in_ready", int'(ir5), 1);
        chk("rst_out_valid", int'(ov5), 0);
        chk("rst_out_bit", int'(ob5), 0);
        chk("rst_out_index", int'(oi5), 0);
        chk("rst_out_last", int'(ol5), 0);
        chk("rst_words_done", int'(wd5), 0);

        // Reset wins over a simultaneous handshake
        rst = 1'b1; iv5 = 1'b1; id5 = 3'b111;
        step();
        rst = 1'b0; iv5 = 1'b0;
        chk("rst_prio_out_valid", int'(ov5), 0);
        chk("rst_prio_in_ready", int'(ir5), 1);

        // Reset mid-word discards the partial word
        send(5, 4'b0111, w);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q5.delete();
        chk("midrst_out_valid", int'(ov5), 0);
        chk("midrst_in_ready", int'(ir5), 1);
        chk("midrst_words_done", int'(wd5), 0);

        // Single word 101, one-cycle latency to the left bit
        send(5, 4'b0101, w);
        chk("w1_out_valid", int'(ov5), 1);
        chk("w1_out_index", int'(oi5), 2);
        chk("w1_out_bit", int'(ob5), 1);
        repeat (3) step();
        chk("w1_words_done", int'(wd5), 1);
        chk("w1_idle", int'(ov5), 0);

        // Back-to-back 110 then 011 with no bubble
        send(5, 4'b0110, w);
        send(5, 4'b0011, w);
        chk("b2b_waits", w, 2);
        chk("b2b_out_valid", int'(ov5), 1);
        chk("b2b_out_index", int'(oi5), 2);
        repeat (3) step();
        chk("b2b_words_done", int'(wd5), 3);
        chk("b2b_idle", int'(ov5), 0);

        // Stall on index 1 of 010
        send(5, 4'b0010, w);
        step();
        out_ready = 1'b0;
        repeat (3) begin
            chk("stall_out_valid", int'(ov5), 1);
            chk("stall_out_index", int'(oi5), 1);
            chk("stall_out_bit", int'(ob5), 1);
            chk("stall_in_ready", int'(ir5), 0);
            step();
        end
        out_ready = 1'b1;
        repeat (2) step();
        chk("stall_words_done", int'(wd5), 4);
        chk("stall_idle", int'(ov5), 0);

        // DEPTH=9: four-bit word starting at index 3
        send(9, 4'b1011, w);
        chk("d9_out_index", int'(oi9), 3);
        chk("d9_out_valid", int'(ov9), 1);
        repeat (4) step();
        chk("d9_words_done", int'(wd9), 1);
        chk("d9_idle", int'(ov9), 0);
        send(9, 4'b0110, w);
        send(9, 4'b1001, w);
        chk("d9_b2b_waits", w, 3);
        repeat (4) step();
        chk("d9_words_done2", int'(wd9), 3);

        // DEPTH=1: one-cycle words, every bit is last
        send(1, 4'b0001, w);
        chk("d1_out_valid", int'(ov1), 1);
        chk("d1_out_last", int'(ol1), 1);
        chk("d1_out_index", int'(oi1), 0);
        send(1, 4'b0000, w);
        chk("d1_b2b_waits", w, 0);
        send(1, 4'b0001, w);
        step();
        chk("d1_idle", int'(ov1), 0);
        chk("d1_words_done", int'(wd1), 3);

        // Counter wrap: 256 words from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        q5.delete();
        for (int k = 0; k < 256; k++) begin
            send(5, 4'(k), w);
        end
        n = 0;
        while (ov5 && n < 20) begin
            step();
            n++;
        end
        chk("wrap_drained", int'(ov5), 0);
        chk("wrap_words_done", int'(wd5), 0);

        chk("q5_empty", q5.size(), 0);
        chk("q9_empty", q9.size(), 0);
        chk("q1_empty", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
